// File: rtl/hazard_pkg.sv
// Hazard control package: FSM state encoding, register-zero constant,
// JR load-use stall length and the stall-statistic saturation limit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        JR_WAIT = 2'b01,
        HALT    = 2'b10
    } state_e;

    localparam logic [3:0]  REG_ZERO             = 4'h0;
    localparam int          JR_LOAD_STALL_CYCLES = 2;
    localparam logic [15:0] STAT_MAX             = 16'hFFFF;

    // True when a used source register names the (non-zero) EX destination.
    function automatic logic src_hit(
        input logic [3:0] dst,
        input logic [3:0] src,
        input logic       used
    );
        return used && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_stat_ctr.sv
// Saturating 16-bit stall-cycle counter used by hazard_ctrl.
// Ports: clk, rst (async, active high), inc, count[15:0].
module hazard_stat_ctr
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != STAT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, two-cycle JR load-use wait,
// taken-branch flush and HLT front-end halt.
// Inputs: clk, rst (async, active high), ID source regs/uses/jr/hlt,
//   EX destination/reg_write/mem_read, branch_taken_ex.
// Outputs: stall_pc, stall_if_id, bubble_id_ex, flush_if_id, halted,
//   and stall_count[15:0] when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_jr,
    input  logic        id_hlt,
    input  logic [3:0]  ex_dst_addr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        branch_taken_ex,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        halted
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam logic WAIT_INIT = 1'(JR_LOAD_STALL_CYCLES - 1);

    state_e state_q;
    state_e state_d;
    logic   wait_q;
    logic   wait_d;

    logic ex_load;
    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic jr_load_use;

    assign ex_load     = ex_mem_read && ex_reg_write;
    assign rs_hit      = src_hit(ex_dst_addr, id_rs_addr, id_uses_rs);
    assign rt_hit      = src_hit(ex_dst_addr, id_rt_addr, id_uses_rt);
    assign load_use    = ex_load && (rs_hit || rt_hit);
    // Non-load writers feeding a JR are covered by the JR forward path.
    assign jr_load_use = ex_load && rs_hit && id_jr;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken_ex) begin
                        flush_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end else if (load_use) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                        if (jr_load_use) begin
                            wait_d  = WAIT_INIT;
                            state_d = JR_WAIT;
                        end
                    end else if (id_hlt) begin
                        state_d = HALT;
                    end
                end
                JR_WAIT: begin
                    if (branch_taken_ex) begin
                        flush_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                        wait_d       = 1'b0;
                        state_d      = RUN;
                    end else begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                        wait_d       = wait_q ? 1'b0 : wait_q;
                        if (!wait_d) begin
                            state_d = RUN;
                        end
                    end
                end
                HALT: begin
                    halted   = 1'b1;
                    stall_pc = 1'b1;
                end
                default: begin
                    wait_d  = 1'b0;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic stat_inc;

    assign stat_inc = stall_pc && (state_q != HALT);

    hazard_stat_ctr u_stat_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (stat_inc),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// random traffic, compared against a behavioural model each cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs_addr, id_rt_addr, ex_dst_addr;
    logic       id_uses_rs, id_uses_rt, id_jr, id_hlt;
    logic       ex_reg_write, ex_mem_read, branch_taken_ex;
    logic       stall_pc, stall_if_id, bubble_id_ex;
    logic       flush_if_id, halted;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model: remaining extra JR stall cycles, halt flag, stall statistic.
    int jr_left = 0;
    bit halt_m  = 1'b0;
    int cnt_m   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_jr           (id_jr),
        .id_hlt          (id_hlt),
        .ex_dst_addr     (ex_dst_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .branch_taken_ex (branch_taken_ex),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .halted          (halted)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    task automatic idle();
        id_rs_addr = 0; id_rt_addr = 0;
        id_uses_rs = 0; id_uses_rt = 0;
        id_jr = 0; id_hlt = 0;
        ex_dst_addr = 0; ex_reg_write = 0;
        ex_mem_read = 0; branch_taken_ex = 0;
    endtask

    // Instruction in ID.
    task automatic id_ins(input int rs, input int rt,
                          input bit urs, input bit urt,
                          input bit jr, input bit hlt);
        id_rs_addr = 4'(rs); id_rt_addr = 4'(rt);
        id_uses_rs = urs; id_uses_rt = urt;
        id_jr = jr; id_hlt = hlt;
    endtask

    // Instruction in EX.
    task automatic ex_ins(input int dst, input bit wr, input bit ld);
        ex_dst_addr = 4'(dst); ex_reg_write = wr; ex_mem_read = ld;
    endtask

    // One cycle: check outputs against the model, then advance it.
    task automatic step(input string tag);
        bit         ld_nz, hz, jr_hz;
        logic [4:0] exp_v, got_v;
        #1;
        ld_nz = ex_mem_read && ex_reg_write && ex_dst_addr != 0;
        hz = ld_nz &&
             ((id_uses_rs && ex_dst_addr == id_rs_addr) ||
              (id_uses_rt && ex_dst_addr == id_rt_addr));
        jr_hz = ld_nz && id_jr && id_uses_rs &&
                ex_dst_addr == id_rs_addr;
        if (rst) begin
            jr_left = 0; halt_m = 0; cnt_m = 0;
        end
        // {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, halted}
        exp_v = 5'b0;
        if (rst)                  exp_v = 5'b00000;
        else if (halt_m)          exp_v = 5'b10001;
        else if (branch_taken_ex) exp_v = 5'b00110;
        else if (jr_left > 0)     exp_v = 5'b11100;
        else if (hz)              exp_v = 5'b11100;
        got_v = {stall_pc, stall_if_id, bubble_id_ex,
                 flush_if_id, halted};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: outputs got %b want %b", tag, got_v, exp_v);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        assert (stall_count === 16'(cnt_m)) else begin
            miscompares++;
            $error("FAIL %s_cnt: stall_count got %h want %h",
                   tag, stall_count, 16'(cnt_m));
        end
`endif
        @(posedge clk);
        if (rst) begin
            jr_left = 0; halt_m = 0; cnt_m = 0;
        end else if (!halt_m) begin
            if (exp_v[4] && cnt_m < 65535) cnt_m++;
            if (branch_taken_ex)  jr_left = 0;
            else if (jr_left > 0) jr_left--;
            else if (hz) begin
                if (jr_hz) jr_left = 2 - 1;
            end else if (id_hlt) halt_m = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("run_idle");

        // load r3; ADD reading r3
        ex_ins(3, 1, 1); id_ins(3, 1, 1, 1, 0, 0);
        step("lu_rs");
        idle(); step("lu_after");
        ex_ins(7, 1, 1); id_ins(2, 7, 1, 1, 0, 0);
        step("lu_rt");
        ex_ins(7, 1, 1); id_ins(2, 7, 1, 0, 0, 0);
        step("rt_unused");

        // load r5; JR r5 -> two stall cycles
        ex_ins(5, 1, 1); id_ins(5, 0, 1, 0, 1, 0);
        step("jr_s1");
        ex_ins(0, 0, 0);
        step("jr_s2");
        step("jr_done");
        ex_ins(5, 1, 0);
        step("jr_alu");

        // load r0 never hazards
        ex_ins(0, 1, 1); id_ins(0, 0, 1, 1, 0, 0);
        step("r0");

        // branch cancels JR_WAIT
        ex_ins(5, 1, 1); id_ins(5, 0, 1, 0, 1, 0);
        step("jrb_s1");
        idle(); branch_taken_ex = 1;
        step("jrb_br");
        idle(); step("jrb_run");

        // branch beats hazard; hazard beats hlt
        ex_ins(4, 1, 1); id_ins(4, 0, 1, 0, 0, 1);
        branch_taken_ex = 1;
        step("br_prio");
        branch_taken_ex = 0;
        step("hz_prio");
        idle(); step("no_halt");

        // HLT then 20 halted cycles despite branches
        id_ins(0, 0, 0, 0, 0, 1);
        step("hlt_go");
        for (int i = 0; i < 20; i++) begin
            idle();
            branch_taken_ex = i[0];
            ex_ins(2, 1, 1); id_ins(2, 2, 1, 1, i[1], 0);
            step("halted");
        end
        idle(); rst = 1'b1;
        step("rst_halt");
        rst = 1'b0;
        step("post_rst");

        // reset in JR_WAIT
        ex_ins(6, 1, 1); id_ins(6, 0, 1, 0, 1, 0);
        step("jrr_s1");
        idle(); rst = 1'b1;
        step("jrr_rst");
        rst = 1'b0;
        step("jrr_run");

`ifdef HAZARD_STATS_EN
        // one load-use stall plus one JR stall -> 3 from zero
        rst = 1'b1; step("st_rst"); rst = 1'b0;
        ex_ins(3, 1, 1); id_ins(3, 0, 1, 0, 0, 0);
        step("st_lu");
        ex_ins(5, 1, 1); id_ins(5, 0, 1, 0, 1, 0);
        step("st_jr1");
        idle(); step("st_jr2");
        step("st_3");
        // run up to 16'hFFFE, then 3 more stalls saturate
        ex_ins(3, 1, 1); id_ins(3, 0, 1, 0, 0, 0);
        while (cnt_m < 16'hFFFE) step("st_fill");
        for (int i = 0; i < 3; i++) step("st_sat");
        idle(); step("st_ffff");
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            id_rs_addr      = 4'($urandom_range(0, 3));
            id_rt_addr      = 4'($urandom_range(0, 3));
            ex_dst_addr     = 4'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_jr           = ($urandom_range(0, 3) == 0);
            id_hlt          = ($urandom_range(0, 39) == 0);
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            rst             = ($urandom_range(0, 29) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  pipeline clock, rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 id_rs_addr, id_rt_addr  input  4 each  source registers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads Rs / Rt.
REQ-006 id_jr  input  1  ID instruction is a jump-register through Rs.
REQ-007 id_hlt  input  1  ID instruction is HLT.
REQ-008 ex_dst_addr  input  4  destination register of the EX instruction.
REQ-009 ex_reg_write, ex_mem_read  input  1 each  EX instruction writes a register / is a load.
REQ-010 branch_taken_ex  input  1  branch resolved taken in EX this cycle.
REQ-011 stall_pc, stall_if_id  output  1 each  hold PC / hold the IF/ID register.
REQ-012 bubble_id_ex  output  1  load NOP into ID/EX.
REQ-013 flush_if_id  output  1  clear IF/ID to NOP.
REQ-014 halted  output  1  pipeline front end halted.
REQ-015 stall_count  output  16  stall-cycle count; present only under HAZARD_STATS_EN.

Function
REQ-016 States SHALL be RUN, JR_WAIT, HALT; state is registered, outputs are combinational from state and inputs.
REQ-017 A load-use hazard SHALL be: ex_mem_read & ex_reg_write & ex_dst_addr!=0 & ((id_uses_rs & ex_dst_addr==id_rs_addr) | (id_uses_rt & ex_dst_addr==id_rt_addr)).
REQ-018 In RUN, a load-use hazard with id_jr=0 SHALL assert stall_pc, stall_if_id and bubble_id_ex for exactly that cycle; the state stays RUN.
REQ-019 In RUN, a load-use hazard on Rs with id_jr=1 SHALL assert the three stall outputs, load a 1-bit wait counter with 1, and enter JR_WAIT.
REQ-020 JR_WAIT SHALL assert stall_pc, stall_if_id and bubble_id_ex every cycle; when the counter is 0 it SHALL return to RUN, giving 2 stall cycles in total.
REQ-021 A JR whose Rs matches a non-load EX writer SHALL NOT stall; the JR forwarding path covers it.
REQ-022 Register 0 SHALL never create a hazard.
REQ-023 branch_taken_ex SHALL assert flush_if_id and bubble_id_ex, deassert stall_pc and stall_if_id, and force RUN from any non-HALT state, cancelling a pending JR_WAIT.
REQ-024 Priority SHALL be branch_taken_ex > hazard stall > id_hlt.
REQ-025 In RUN, id_hlt with no hazard and no branch SHALL enter HALT at the next edge.
REQ-026 HALT SHALL assert halted and stall_pc continuously and ignore all inputs until reset.
REQ-027 All other outputs SHALL be 0 when no condition applies.

Reset
REQ-028 rst SHALL force RUN, clear the wait counter, and drive every output to 0 (stall_count=0), independent of clk.
REQ-029 Reset asserted during JR_WAIT or HALT SHALL abandon the state; the first cycle after release SHALL be RUN with no stall.

Configuration
REQ-030 Macro HAZARD_STATS_EN SHALL compile in stall_count: +1 on each cycle stall_pc=1 outside HALT, saturating at 16'hFFFF.
REQ-031 Without HAZARD_STATS_EN, the stall_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package hazard_pkg SHALL hold the state encoding (RUN=2'b00, JR_WAIT=2'b01, HALT=2'b10), REG_ZERO=4'h0 and JR_LOAD_STALL_CYCLES=2.
REQ-033 The saturating counter SHALL be a sub-module hazard_stat_ctr, instantiated only under HAZARD_STATS_EN.

Verification
REQ-034 Load r3 in EX with reg_write; ADD in ID with rs=3 -> one cycle with stall_pc=stall_if_id=bubble_id_ex=1, then all 0.
REQ-035 Load r5 in EX; JR r5 in ID -> stall outputs high for exactly 2 cycles, state back to RUN; ALU writing r5 in EX with JR r5 -> no stall.
REQ-036 Load r0 in EX; ID reads r0 -> no stall.
REQ-037 JR_WAIT first cycle plus branch_taken_ex=1 -> flush_if_id=bubble_id_ex=1, stall_pc=0, RUN on the next cycle.
REQ-038 id_hlt in RUN -> halted=1 and stall_pc=1 from the next cycle for 20 cycles despite branch_taken_ex pulses; rst pulse mid-HALT -> all outputs 0 immediately.
REQ-039 With HAZARD_STATS_EN: one load-use stall plus one JR stall -> stall_count=3; preload 16'hFFFE plus 3 stalls -> 16'hFFFF.
